irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_pkg.sv | 18 +
 rtl/irq_prio_enc.sv | 23 ++
 rtl/irq_ctrl.sv | 139 +++++++++++++
 tb/tb_irq_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register indices and
// the request-sequencing state encoding.
package irq_pkg;

    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_MODE    = 2'd1;
    localparam logic [1:0] REG_PENDING = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int STATUS_IRQ_BIT = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set bit of vec wins.
module irq_prio_enc #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 8
) (
    input  logic [NUM_IRQ-1:0] vec,
    output logic               valid,
    output logic [ID_W-1:0]    idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                valid = 1'b1;
                idx   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge/level capture into PENDING, enable-gated
// fixed-priority arbitration, and a registered irq/irq_id handshake.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] src,
    input  logic               sel,
    input  logic               wr,
    input  logic [1:0]         addr,
    input  logic [15:0]        wdata,
    output logic [15:0]        rdata,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack
);

    localparam int SW = (ID_W < 15) ? ID_W : 15;

    logic [NUM_IRQ-1:0] enable_q, mode_q, pending_q, prev_q;
    logic [NUM_IRQ-1:0] pending_d, rise, w1c, ack_clr, id_hot, cand;
    logic               wr_en, ack_take, win_vld, keep;
    logic [ID_W-1:0]    win_id;
    irq_state_e         state_q, state_d;
    logic               irq_q, irq_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic               unused_wdata;

    assign unused_wdata = ^wdata;

    assign wr_en    = sel & wr;
    assign rise     = src & ~prev_q;
    assign w1c      = (wr_en && addr == REG_PENDING) ? wdata[NUM_IRQ-1:0] : '0;
    assign ack_take = (state_q == ST_ASSERT) && irq_ack;

    always_comb begin
        id_hot = '0;
        for (int i = 0; i < NUM_IRQ; i++)
            id_hot[i] = (irq_id_q == ID_W'(i));
    end

    // Ack only retires edge-mode sources; level bits simply track src.
    assign ack_clr = ack_take ? (id_hot & mode_q) : '0;

    // A fresh edge is OR-ed in after the clear so it survives W1C/ack.
    assign pending_d = (mode_q & ((pending_q & ~(w1c | ack_clr)) | rise))
                     | (~mode_q & src);

    assign cand = pending_q & enable_q;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio (
        .vec   (cand),
        .valid (win_vld),
        .idx   (win_id)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_q  <= '0;
            mode_q    <= '1;
            pending_q <= '0;
            prev_q    <= '0;
        end else begin
            prev_q    <= src;
            pending_q <= pending_d;
            if (wr_en && addr == REG_ENABLE) enable_q <= wdata[NUM_IRQ-1:0];
            if (wr_en && addr == REG_MODE)   mode_q   <= wdata[NUM_IRQ-1:0];
        end
    end

    // The granted source stays granted while it is still pending and enabled.
    assign keep = |(id_hot & cand);

    always_comb begin
        state_d  = state_q;
        irq_d    = irq_q;
        irq_id_d = irq_id_q;
        case (state_q)
            ST_IDLE: begin
                irq_d = 1'b0;
                if (win_vld) begin
                    state_d  = ST_ASSERT;
                    irq_d    = 1'b1;
                    irq_id_d = win_id;
                end
            end
            ST_ASSERT: begin
                if (irq_ack || !keep) begin
                    state_d = ST_GAP;
                    irq_d   = 1'b0;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            irq_q    <= 1'b0;
            irq_id_q <= '0;
        end else begin
            state_q  <= state_d;
            irq_q    <= irq_d;
            irq_id_q <= irq_id_d;
        end
    end

    assign irq    = irq_q;
    assign irq_id = irq_id_q;

    always_comb begin
        rdata = '0;
        case (addr)
            REG_ENABLE:  rdata[NUM_IRQ-1:0] = enable_q;
            REG_MODE:    rdata[NUM_IRQ-1:0] = mode_q;
            REG_PENDING: rdata[NUM_IRQ-1:0] = pending_q;
            default: begin
                rdata[STATUS_IRQ_BIT] = irq_q;
                rdata[SW-1:0]         = irq_id_q[SW-1:0];
            end
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed table-driven bench for irq_ctrl, plus a hand-written
// asynchronous-reset sequence.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  src = '0;
    logic        sel = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        irq;
    logic [7:0]  irq_id;
    logic        irq_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.NUM_IRQ(8), .ID_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .src     (src),
        .sel     (sel),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq),
        .irq_id  (irq_id),
        .irq_ack (irq_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  src;
        logic        w;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic        ack;
        logic        exp_irq;
        logic [7:0]  exp_id;
        logic [15:0] exp_rd;
    } vec_t;

    localparam int NV = 50;
    vec_t vt[NV];

    function automatic vec_t mk(logic [7:0] s, logic w, logic [1:0] a, logic [15:0] d,
                                logic k, logic ei, logic [7:0] eid, logic [15:0] erd);
        vec_t v;
        v.src = s; v.w = w; v.addr = a; v.wdata = d; v.ack = k;
        v.exp_irq = ei; v.exp_id = eid; v.exp_rd = erd;
        return v;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    initial begin
        // edge on src[2] with ENABLE=0x0005, then ack
        vt[0]  = mk(8'h00, 1, 2'd0, 16'h0005, 0, 0, 8'd0, 16'h0005);
        vt[1]  = mk(8'h04, 0, 2'd2, 16'h0000, 0, 0, 8'd0, 16'h0004);
        vt[2]  = mk(8'h04, 0, 2'd3, 16'h0000, 0, 1, 8'd2, 16'h8002);
        vt[3]  = mk(8'h04, 0, 2'd2, 16'h0000, 1, 0, 8'd2, 16'h0000);
        vt[4]  = mk(8'h00, 0, 2'd3, 16'h0000, 0, 0, 8'd2, 16'h0002);
        // simultaneous edges on src[0] and src[2]
        vt[5]  = mk(8'h05, 0, 2'd2, 16'h0000, 0, 0, 8'd2, 16'h0005);
        vt[6]  = mk(8'h05, 0, 2'd3, 16'h0000, 0, 1, 8'd0, 16'h8000);
        vt[7]  = mk(8'h05, 0, 2'd2, 16'h0000, 1, 0, 8'd0, 16'h0004);
        vt[8]  = mk(8'h05, 0, 2'd3, 16'h0000, 0, 0, 8'd0, 16'h0000);
        vt[9]  = mk(8'h05, 0, 2'd3, 16'h0000, 0, 1, 8'd2, 16'h8002);
        vt[10] = mk(8'h05, 0, 2'd2, 16'h0000, 1, 0, 8'd2, 16'h0000);
        vt[11] = mk(8'h00, 0, 2'd3, 16'h0000, 0, 0, 8'd2, 16'h0002);
        // higher-priority src[3] arrives while id 5 is asserted
        vt[12] = mk(8'h00, 1, 2'd0, 16'h0028, 0, 0, 8'd2, 16'h0028);
        vt[13] = mk(8'h20, 0, 2'd3, 16'h0000, 0, 0, 8'd2, 16'h0002);
        vt[14] = mk(8'h20, 0, 2'd3, 16'h0000, 0, 1, 8'd5, 16'h8005);
        vt[15] = mk(8'h28, 0, 2'd3, 16'h0000, 0, 1, 8'd5, 16'h8005);
        vt[16] = mk(8'h28, 0, 2'd2, 16'h0000, 0, 1, 8'd5, 16'h0028);
        vt[17] = mk(8'h28, 0, 2'd2, 16'h0000, 1, 0, 8'd5, 16'h0008);
        vt[18] = mk(8'h28, 0, 2'd3, 16'h0000, 0, 0, 8'd5, 16'h0005);
        vt[19] = mk(8'h28, 0, 2'd3, 16'h0000, 0, 1, 8'd3, 16'h8003);
        vt[20] = mk(8'h28, 0, 2'd2, 16'h0000, 1, 0, 8'd3, 16'h0000);
        vt[21] = mk(8'h00, 0, 2'd3, 16'h0000, 0, 0, 8'd3, 16'h0003);
        // level mode on bit1, upper MODE bits ignored
        vt[22] = mk(8'h00, 1, 2'd1, 16'hFFFD, 0, 0, 8'd3, 16'h00FD);
        vt[23] = mk(8'h02, 1, 2'd0, 16'h0002, 0, 0, 8'd3, 16'h0002);
        vt[24] = mk(8'h02, 0, 2'd3, 16'h0000, 0, 1, 8'd1, 16'h8001);
        vt[25] = mk(8'h02, 0, 2'd2, 16'h0000, 1, 0, 8'd1, 16'h0002);
        vt[26] = mk(8'h02, 0, 2'd3, 16'h0000, 0, 0, 8'd1, 16'h0001);
        vt[27] = mk(8'h02, 0, 2'd3, 16'h0000, 0, 1, 8'd1, 16'h8001);
        vt[28] = mk(8'h00, 0, 2'd3, 16'h0000, 0, 1, 8'd1, 16'h8001);
        vt[29] = mk(8'h00, 0, 2'd3, 16'h0000, 0, 0, 8'd1, 16'h0001);
        vt[30] = mk(8'h00, 0, 2'd3, 16'h0000, 0, 0, 8'd1, 16'h0001);
        vt[31] = mk(8'h00, 1, 2'd1, 16'h00FF, 0, 0, 8'd1, 16'h00FF);
        // edge on src[4] together with W1C of bit4
        vt[32] = mk(8'h10, 1, 2'd2, 16'h0010, 0, 0, 8'd1, 16'h0010);
        vt[33] = mk(8'h10, 1, 2'd2, 16'h0010, 0, 0, 8'd1, 16'h0000);
        // W1C of the asserted source drops irq without ack
        vt[34] = mk(8'h00, 1, 2'd0, 16'h0010, 0, 0, 8'd1, 16'h0010);
        vt[35] = mk(8'h10, 0, 2'd2, 16'h0000, 0, 0, 8'd1, 16'h0010);
        vt[36] = mk(8'h10, 0, 2'd3, 16'h0000, 0, 1, 8'd4, 16'h8004);
        vt[37] = mk(8'h10, 1, 2'd2, 16'h0010, 0, 1, 8'd4, 16'h0000);
        vt[38] = mk(8'h10, 0, 2'd3, 16'h0000, 0, 0, 8'd4, 16'h0004);
        vt[39] = mk(8'h10, 0, 2'd3, 16'h0000, 0, 0, 8'd4, 16'h0004);
        // disabling the asserted source drops irq; ack in IDLE ignored
        vt[40] = mk(8'h00, 0, 2'd3, 16'h0000, 0, 0, 8'd4, 16'h0004);
        vt[41] = mk(8'h10, 0, 2'd2, 16'h0000, 0, 0, 8'd4, 16'h0010);
        vt[42] = mk(8'h10, 0, 2'd3, 16'h0000, 0, 1, 8'd4, 16'h8004);
        vt[43] = mk(8'h10, 1, 2'd0, 16'h0000, 0, 1, 8'd4, 16'h0000);
        vt[44] = mk(8'h10, 0, 2'd3, 16'h0000, 0, 0, 8'd4, 16'h0004);
        vt[45] = mk(8'h10, 0, 2'd2, 16'h0000, 0, 0, 8'd4, 16'h0010);
        vt[46] = mk(8'h10, 0, 2'd3, 16'h0000, 1, 0, 8'd4, 16'h0004);
        vt[47] = mk(8'h10, 0, 2'd2, 16'h0000, 0, 0, 8'd4, 16'h0010);
        // re-enable and leave irq asserted for the reset test
        vt[48] = mk(8'h10, 1, 2'd0, 16'h0010, 0, 0, 8'd4, 16'h0010);
        vt[49] = mk(8'h10, 0, 2'd3, 16'h0000, 0, 1, 8'd4, 16'h8004);

        // reset state
        #12;
        chk("reset_irq", {15'd0, irq}, 16'h0000);
        chk("reset_id", {8'd0, irq_id}, 16'h0000);
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            chk($sformatf("reset_reg%0d", a), rdata, (a == 1) ? 16'h00FF : 16'h0000);
        end
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < NV; k++) begin
            src     = vt[k].src;
            sel     = vt[k].w;
            wr      = vt[k].w;
            addr    = vt[k].addr;
            wdata   = vt[k].wdata;
            irq_ack = vt[k].ack;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_irq", k), {15'd0, irq}, {15'd0, vt[k].exp_irq});
            chk($sformatf("v%0d_id", k), {8'd0, irq_id}, {8'd0, vt[k].exp_id});
            chk($sformatf("v%0d_rdata", k), rdata, vt[k].exp_rd);
        end

        // asynchronous reset while irq is high, away from any clock edge
        sel = 1'b0; wr = 1'b0; irq_ack = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_irq", {15'd0, irq}, 16'h0000);
        chk("async_rst_id", {8'd0, irq_id}, 16'h0000);
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            chk($sformatf("async_rst_reg%0d", a), rdata, (a == 1) ? 16'h00FF : 16'h0000);
        end
        src = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        addr = 2'd2;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_irq", {15'd0, irq}, 16'h0000);
        chk("post_rst_pending", rdata, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
